out_buf_writer: RTL and testbench
=================================

// Module: out_buf_writer
// PURPOSE
//   Write side of the 768-entry dual-port output buffer (InOutbuf). Accepts processed
//   16-bit samples from the DSP core over a valid/ready handshake and drives the buffer
//   write port (Outa/Outd/OutBufWea) with a wrapping write address. Tracks occupancy
//   against the reader's consumption ticks and releases the reader (buf_ready) only
//   once the buffer is primed. Flags overrun and underrun.
// PARAMETERS
//   DEPTH   768  buffer entries; write address wraps DEPTH-1 -> 0
//   ADDR_W  10   address and occupancy width; DEPTH <= 2**ADDR_W
//   DATA_W  16   sample width
//   PRIME   384  occupancy at which PRIME -> RUN; 1 <= PRIME <= DEPTH
// PORTS
//   sys_clk     in   1       single clock, all logic rising-edge
//   reset       in   1       synchronous, active-low
//   flush       in   1       synchronous restart: pointers/occupancy cleared, back to PRIME
//   in_data     in   DATA_W  sample from DSP core
//   in_valid    in   1       in_data valid
//   in_ready    out  1       writer can accept; transfer when in_valid & in_ready
//   rd_tick     in   1       reader consumed one sample this cycle (reader's ready strobe)
//   buf_ready   out  1       buffer primed; drives the reader's ready/enable
//   Outa        out  ADDR_W  buffer write address
//   Outd        out  DATA_W  buffer write data
//   OutBufWea   out  1       buffer write enable
//   level       out  ADDR_W  occupancy (accepted minus consumed)
//   frame_done  out  1       1-cycle pulse on the write at address DEPTH-1
//   overrun     out  1       sticky: in_valid held while full in RUN
//   underrun    out  1       sticky: rd_tick while level==0 in RUN
// BEHAVIOUR
//   Reset (reset==0 at clock edge): state=PRIME; wr_ptr=0, level=0; Outa=0, Outd=0,
//     OutBufWea=0, frame_done=0, buf_ready=0, overrun=0, underrun=0. in_ready=1 after reset.
//   Reset or flush mid-operation takes effect at that edge; a transfer accepted in that
//     same cycle is discarded (no write issued next cycle). flush does not clear sticky flags;
//     only reset does.
//   States: PRIME: in_ready = (level < DEPTH); rd_tick ignored; buf_ready=0.
//     PRIME -> RUN at the edge where next level >= PRIME; buf_ready=1 from next cycle.
//     RUN: in_ready = (level < DEPTH); rd_tick decrements level; buf_ready=1.
//     RUN -> PRIME on underrun event (rd_tick with level==0): level stays 0, wr_ptr kept,
//     underrun set.
//   Accept: transfer at edge k -> Outa=wr_ptr, Outd=in_data, OutBufWea=1 during cycle k+1
//     (1-cycle registered latency); wr_ptr += 1, wrapping DEPTH-1 -> 0 (not 2**ADDR_W).
//     OutBufWea=0 in any cycle with no accepted transfer at the prior edge; Outa/Outd hold.
//   frame_done asserted in the same cycle as the OutBufWea write to address DEPTH-1.
//   level: +1 on accept, -1 on counted rd_tick, unchanged when both occur in the same cycle;
//     never exceeds DEPTH, never below 0. Full = level==DEPTH -> in_ready=0 combinationally
//     from registered level; a same-cycle rd_tick does not raise in_ready until next cycle.
//   overrun set in RUN when in_valid=1 and level==DEPTH; data is not dropped, core stalls.
//   Reader address is implicit: reader counts its own 0..DEPTH-1 on buf_ready & rd_tick;
//     correct pairing requires both to start at 0 after reset/flush.
// TESTING
//   Prime: reset, stream 384 samples 0x0000..0x017F continuous valid -> writes addr 0..383,
//     OutBufWea 1 cycle after each accept, buf_ready rises cycle after 384th accept, level=384.
//   Wrap: stream 770 samples with rd_tick each cycle after prime -> addr 767 then 0,1;
//     frame_done single pulse with Outa=767; level stays 384.
//   Full: prime, no rd_tick, keep in_valid=1 -> level stops at 768, in_ready=0, overrun=1;
//     one rd_tick -> level 767, in_ready=1 next cycle, next write to addr 0.
//   Simultaneous: accept and rd_tick same cycle at level 500 -> level 500; rd_tick in PRIME
//     -> level unchanged.
//   Underrun: RUN at level 1, two rd_ticks, no input -> level 0, underrun=1, buf_ready=0,
//     state PRIME; refill to 384 -> buf_ready=1.
//   Flush/reset mid-stream: flush at level 200 with accept same cycle -> no write next cycle,
//     level 0, Outa next write 0, flags kept; reset clears flags and all outputs to 0.

Source files
------------

// File: rtl/out_buf_writer.sv
// Write side of the dual-port output buffer: accepts DSP samples, drives the buffer
// write port with a wrapping address, and gates the reader until the buffer is primed.
module out_buf_writer #(
    parameter int DEPTH  = 768,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int PRIME  = 384
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rd_tick,
    output logic              buf_ready,
    output logic [ADDR_W-1:0] Outa,
    output logic [DATA_W-1:0] Outd,
    output logic              OutBufWea,
    output logic [ADDR_W-1:0] level,
    output logic              frame_done,
    output logic              overrun,
    output logic              underrun
);

    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRIME_L = ADDR_W'(PRIME);
    localparam logic [ADDR_W-1:0] ONE_L   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_L  = '0;

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] level_q, level_d;
    logic [ADDR_W-1:0] outa_q, outa_d;
    logic [DATA_W-1:0] outd_q, outd_d;
    logic              wea_q, wea_d;
    logic              frame_q, frame_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;

    logic              run;
    logic              accept;
    logic              tick_cnt;
    logic              underrun_ev;

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state_q    <= ST_PRIME;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            outa_q     <= '0;
            outd_q     <= '0;
            wea_q      <= 1'b0;
            frame_q    <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            outa_q     <= outa_d;
            outd_q     <= outd_d;
            wea_q      <= wea_d;
            frame_q    <= frame_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    // Reader ticks only count in RUN; a tick at level 0 is an underrun, not a decrement.
    always_comb begin
        run         = (state_q == ST_RUN);
        accept      = in_valid & in_ready;
        underrun_ev = run & rd_tick & (level_q == ZERO_L);
        tick_cnt    = run & rd_tick & (level_q != ZERO_L);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        outa_d     = outa_q;
        outd_d     = outd_q;
        wea_d      = 1'b0;
        frame_d    = 1'b0;
        overrun_d  = overrun_q | (run & in_valid & (level_q == DEPTH_L));
        underrun_d = underrun_q | underrun_ev;

        if (accept) begin
            outa_d   = wr_ptr_q;
            outd_d   = in_data;
            wea_d    = 1'b1;
            frame_d  = (wr_ptr_q == LAST_L);
            wr_ptr_d = (wr_ptr_q == LAST_L) ? ZERO_L : wr_ptr_q + ONE_L;
        end

        case ({accept, tick_cnt})
            2'b10:   level_d = level_q + ONE_L;
            2'b01:   level_d = level_q - ONE_L;
            default: level_d = level_q;
        endcase

        case (state_q)
            ST_PRIME: if (level_d >= PRIME_L) state_d = ST_RUN;
            ST_RUN:   if (underrun_ev) state_d = ST_PRIME;
            default:  state_d = ST_PRIME;
        endcase

        // Flush drops any same-cycle transfer so the reader and writer restart in step.
        if (flush) begin
            state_d  = ST_PRIME;
            wr_ptr_d = '0;
            level_d  = '0;
            outa_d   = outa_q;
            outd_d   = outd_q;
            wea_d    = 1'b0;
            frame_d  = 1'b0;
        end
    end

    always_comb begin
        in_ready   = (level_q < DEPTH_L);
        buf_ready  = (state_q == ST_RUN);
        Outa       = outa_q;
        Outd       = outd_q;
        OutBufWea  = wea_q;
        level      = level_q;
        frame_done = frame_q;
        overrun    = overrun_q;
        underrun   = underrun_q;
    end

endmodule

// File: tb/tb_out_buf_writer.sv
// Directed bench for out_buf_writer: priming, wrap, full/overrun, simultaneous
// accept+tick, underrun, flush and reset, with hand-computed expectations.
module tb_out_buf_writer;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rd_tick;
    logic        buf_ready;
    logic [9:0]  Outa;
    logic [15:0] Outd;
    logic        OutBufWea;
    logic [9:0]  level;
    logic        frame_done;
    logic        overrun;
    logic        underrun;

    int total = 0;
    int bad   = 0;
    int frames;

    always #5 sys_clk = ~sys_clk;

    out_buf_writer dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_tick    (rd_tick),
        .buf_ready  (buf_ready),
        .Outa       (Outa),
        .Outd       (Outd),
        .OutBufWea  (OutBufWea),
        .level      (level),
        .frame_done (frame_done),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic t, input logic f);
        in_valid = v;
        in_data  = d;
        rd_tick  = t;
        flush    = f;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 16'h0, 0, 0);
        applyStimulus(1, 16'h1111, 1, 0);
        checkOutput("rst_outa", Outa, 0);
        checkOutput("rst_outd", Outd, 0);
        checkOutput("rst_wea", OutBufWea, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_bufrdy", buf_ready, 0);
        checkOutput("rst_inrdy", in_ready, 1);
        checkOutput("rst_flags", {overrun, underrun, frame_done}, 0);
        reset = 1'b1;

        // Prime: 384 samples, buffer released right after the last one.
        for (int i = 0; i < 384; i++) begin
            applyStimulus(1, 16'(i), 0, 0);
            checkOutput("prime_wea", OutBufWea, 1);
            checkOutput("prime_addr", Outa, i);
            checkOutput("prime_data", Outd, i);
            checkOutput("prime_bufrdy", buf_ready, (i == 383));
        end
        checkOutput("prime_level", level, 384);
        applyStimulus(0, 16'h0, 0, 0);
        checkOutput("idle_wea", OutBufWea, 0);
        checkOutput("idle_hold", Outa, 383);

        // Wrap: 386 writes with a tick each cycle, 384..767 then 0,1.
        frames = 0;
        for (int k = 0; k < 386; k++) begin
            applyStimulus(1, 16'(k + 384), 1, 0);
            checkOutput("wrap_addr", Outa, (384 + k) % 768);
            checkOutput("wrap_level", level, 384);
            checkOutput("wrap_frame", frame_done, (((384 + k) % 768) == 767));
            if (frame_done) frames++;
        end
        checkOutput("wrap_frames", frames, 1);

        // Simultaneous accept and tick at level 500.
        for (int i = 0; i < 116; i++) applyStimulus(1, 16'h2000, 0, 0);
        checkOutput("fill500", level, 500);
        applyStimulus(1, 16'hBEEF, 1, 0);
        checkOutput("simul_level", level, 500);
        checkOutput("simul_addr", Outa, 118);
        checkOutput("simul_data", Outd, 16'hBEEF);

        // Underrun: drain to 1, then two ticks.
        for (int i = 0; i < 499; i++) applyStimulus(0, 16'h0, 1, 0);
        checkOutput("drain_level", level, 1);
        applyStimulus(0, 16'h0, 1, 0);
        checkOutput("drain0_level", level, 0);
        checkOutput("drain0_bufrdy", buf_ready, 1);
        checkOutput("drain0_under", underrun, 0);
        applyStimulus(0, 16'h0, 1, 0);
        checkOutput("under_flag", underrun, 1);
        checkOutput("under_bufrdy", buf_ready, 0);
        checkOutput("under_level", level, 0);

        // Ticks in PRIME are ignored; refill keeps the write pointer.
        for (int i = 0; i < 5; i++) applyStimulus(1, 16'h3000, 0, 0);
        applyStimulus(0, 16'h0, 1, 0);
        checkOutput("prime_tick_level", level, 5);
        checkOutput("refill_addr", Outa, 123);
        for (int i = 0; i < 378; i++) applyStimulus(1, 16'h3001, 0, 0);
        checkOutput("refill_notyet", buf_ready, 0);
        applyStimulus(1, 16'h3002, 0, 0);
        checkOutput("refill_bufrdy", buf_ready, 1);
        checkOutput("refill_level", level, 384);
        checkOutput("refill_last", Outa, 502);

        // Full: fill from empty past 768 with valid held.
        applyStimulus(0, 16'h0, 0, 1);
        checkOutput("flush_level", level, 0);
        checkOutput("flush_bufrdy", buf_ready, 0);
        for (int i = 0; i < 770; i++) applyStimulus(1, 16'(i), 0, 0);
        checkOutput("full_level", level, 768);
        checkOutput("full_inrdy", in_ready, 0);
        checkOutput("full_over", overrun, 1);
        checkOutput("full_wea", OutBufWea, 0);
        checkOutput("full_hold", Outa, 767);
        applyStimulus(1, 16'h1234, 1, 0);
        checkOutput("full_tick_level", level, 767);
        checkOutput("full_tick_inrdy", in_ready, 1);
        checkOutput("full_tick_wea", OutBufWea, 0);
        applyStimulus(1, 16'h1234, 0, 0);
        checkOutput("full_next_wea", OutBufWea, 1);
        checkOutput("full_next_addr", Outa, 0);
        checkOutput("full_next_data", Outd, 16'h1234);
        checkOutput("full_next_level", level, 768);

        // Flush at level 200 with a same-cycle accept.
        applyStimulus(0, 16'h0, 0, 1);
        for (int i = 0; i < 200; i++) applyStimulus(1, 16'(i + 256), 0, 0);
        checkOutput("mid_level", level, 200);
        applyStimulus(1, 16'hDEAD, 0, 1);
        checkOutput("mflush_wea", OutBufWea, 0);
        checkOutput("mflush_level", level, 0);
        checkOutput("mflush_hold", Outa, 199);
        checkOutput("mflush_flags", {overrun, underrun}, 2'b11);
        applyStimulus(1, 16'h0055, 0, 0);
        checkOutput("post_wea", OutBufWea, 1);
        checkOutput("post_addr", Outa, 0);
        checkOutput("post_data", Outd, 16'h0055);
        checkOutput("post_level", level, 1);

        // Reset mid-stream clears everything, including sticky flags.
        reset = 1'b0;
        applyStimulus(1, 16'h0077, 1, 0);
        checkOutput("rst2_outa", Outa, 0);
        checkOutput("rst2_outd", Outd, 0);
        checkOutput("rst2_wea", OutBufWea, 0);
        checkOutput("rst2_level", level, 0);
        checkOutput("rst2_flags", {overrun, underrun, frame_done, buf_ready}, 0);
        checkOutput("rst2_inrdy", in_ready, 1);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
